// File: rtl/crosshair_render_pkg.sv
// rtl/crosshair_render_pkg.sv - shared video types and constants for the crosshair path
package crosshair_render_pkg;

    // 24-bit RGB colour, 8 bits per channel (R in the top byte)
    typedef logic [23:0] color_t;

    localparam color_t COLOR_DEF   = 24'hFF_00_00;

    // Visible screen size
    localparam int     SCREEN_W    = 1024;
    localparam int     SCREEN_H    = 768;

    // Crosshair centre after reset; the mover starts from the same point
    localparam int     X_RESET_DEF = 400;
    localparam int     Y_RESET_DEF = 300;

endpackage

// File: rtl/crosshair_render_abs_diff.sv
// rtl/crosshair_render_abs_diff.sv - magnitude of the difference of two 11-bit unsigned values
//
// Ports:
//   a, b : 11-bit unsigned operands
//   mag  : |a - b|, 11 bits (never wraps, max 2047)
module crosshair_render_abs_diff (
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [10:0] mag
);

    // Zero-extended 12-bit subtraction; bit 11 is the sign of a - b
    logic [11:0] diff;

    assign diff = {1'b0, a} - {1'b0, b};

    // Magnitude is always < 2048, so negating the low 11 bits is exact
    assign mag = diff[11] ? (~diff[10:0] + 11'd1) : diff[10:0];

endmodule

// File: rtl/crosshair_render.sv
// rtl/crosshair_render.sv - per-pixel crosshair renderer with frame-latched coordinates
//
// Ports:
//   clk, reset_n                     pixel clock, synchronous active-low reset
//   hcount, vcount                   current pixel column / row from the timing generator
//   hsync_in, vsync_in, blank_in     syncs (active low) and blank from the timing generator
//   x_in, y_in, show, blink          crosshair centre and controls from the mover
//   pixel                            COLOR on crosshair pixels, else 0
//   hsync_out, vsync_out, blank_out  sync/blank delayed two cycles to match pixel
//   frame_tick                       one-cycle pulse after coordinates are latched
module crosshair_render
    import crosshair_render_pkg::*;
#(
    parameter color_t COLOR        = COLOR_DEF,
    parameter int     ARM          = 16,
    parameter int     HALF_T       = 1,
    parameter int     BLINK_FRAMES = 15,
    parameter int     X_RESET      = X_RESET_DEF,
    parameter int     Y_RESET      = Y_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        show,
    input  logic        blink,
    output color_t      pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        frame_tick
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Frame-latched state
    logic            vsync_prev;
    logic [10:0]     x_l;
    logic [9:0]      y_l;
    logic            show_l;
    logic [FC_W-1:0] fc;
    logic            ph;

    // Stage 1 registers
    logic [10:0]     dx_q;
    logic [10:0]     dy_q;
    logic            hs_q;
    logic            vs_q;
    logic            bl_q;
    logic            en_q;

    logic [10:0]     dx;
    logic [10:0]     dy;
    logic            frame_start;
    logic            horiz;
    logic            vert;

    assign frame_start = vsync_prev & ~vsync_in;

    crosshair_render_abs_diff u_abs_x (
        .a   (hcount),
        .b   (x_l),
        .mag (dx)
    );

    crosshair_render_abs_diff u_abs_y (
        .a   ({1'b0, vcount}),
        .b   ({1'b0, y_l}),
        .mag (dy)
    );

    // Coordinates, enable and blink phase change only on the vsync falling edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vsync_prev <= 1'b1;
            x_l        <= 11'(X_RESET);
            y_l        <= 10'(Y_RESET);
            show_l     <= 1'b0;
            fc         <= '0;
            ph         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            frame_tick <= frame_start;
            if (frame_start) begin
                x_l    <= x_in;
                y_l    <= y_in;
                show_l <= show;
                if (!blink) begin
                    fc <= '0;
                    ph <= 1'b1;
                end else if (fc == FC_W'(BLINK_FRAMES - 1)) begin
                    fc <= '0;
                    ph <= ~ph;
                end else begin
                    fc <= fc + 1'b1;
                end
            end
        end
    end

    // Stage 1: distances plus delayed syncs. The enable travels with the
    // distances so every pixel is judged against the state it was measured with.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bl_q <= 1'b1;
            en_q <= 1'b0;
        end else begin
            dx_q <= dx;
            dy_q <= dy;
            hs_q <= hsync_in;
            vs_q <= vsync_in;
            bl_q <= blank_in;
            en_q <= show_l & ph;
        end
    end

    assign horiz = (dy_q <= 11'(HALF_T)) && (dx_q <= 11'(ARM));
    assign vert  = (dx_q <= 11'(HALF_T)) && (dy_q <= 11'(ARM));

    // Stage 2: hit test and colour mux
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel     <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            blank_out <= 1'b1;
        end else begin
            pixel     <= ((horiz | vert) & en_q & ~bl_q) ? COLOR : '0;
            hsync_out <= hs_q;
            vsync_out <= vs_q;
            blank_out <= bl_q;
        end
    end

endmodule

// File: tb/tb_crosshair_render.sv
// tb/tb_crosshair_render.sv - scoreboard testbench for crosshair_render
module tb_crosshair_render;
    import crosshair_render_pkg::*;

    localparam color_t C_COLOR = 24'hFF_00_00;
    localparam int     C_ARM   = 16;
    localparam int     C_HT    = 1;
    localparam int     C_BF    = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync_in, vsync_in, blank_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        show, blink;
    color_t      pixel;
    logic        hsync_out, vsync_out, blank_out, frame_tick;

    crosshair_render #(
        .COLOR(C_COLOR), .ARM(C_ARM), .HALF_T(C_HT), .BLINK_FRAMES(C_BF),
        .X_RESET(X_RESET_DEF), .Y_RESET(Y_RESET_DEF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .x_in(x_in), .y_in(y_in), .show(show), .blink(blink),
        .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .blank_out(blank_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] pix;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        ft;
    } out_t;

    localparam out_t RST_OUT = '{pix: 24'h0, hs: 1'b1, vs: 1'b1, bl: 1'b1, ft: 1'b0};

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_ticks  = 0;

    // Reference state: what the renderer should currently be drawing
    int   mx, my, krun;
    bit   mshow, prev_vs;
    out_t d1, d2;

    function automatic out_t expect_px(input int h, input int v, input bit bl,
                                       input bit hs, input bit vs);
        out_t o;
        int   dx, dy;
        bit   vis, hit;
        dx  = (h > mx) ? h - mx : mx - h;
        dy  = (v > my) ? v - my : my - v;
        // Blink: visible for C_BF frame starts, hidden for the next C_BF, ...
        vis = mshow && (((krun / C_BF) % 2) == 0);
        hit = vis && ((dy <= C_HT && dx <= C_ARM) || (dx <= C_HT && dy <= C_ARM));
        o.pix = (hit && !bl) ? C_COLOR : 24'h0;
        o.hs  = hs;
        o.vs  = vs;
        o.bl  = bl;
        o.ft  = 1'b0;
        return o;
    endfunction

    // One clock: model the edge, queue the output expected right after it
    task automatic tick();
        out_t e;
        bit   fs;
        @(posedge clk);
        n_ticks++;
        if (!reset_n) begin
            d1 = RST_OUT; d2 = RST_OUT; fs = 1'b0;
            mx = X_RESET_DEF; my = Y_RESET_DEF; mshow = 1'b0; krun = 0; prev_vs = 1'b1;
        end else begin
            fs = prev_vs && !vsync_in;
            d2 = d1;
            d1 = expect_px(int'(hcount), int'(vcount), blank_in, hsync_in, vsync_in);
            if (fs) begin
                mx = int'(x_in); my = int'(y_in); mshow = show;
                krun = blink ? krun + 1 : 0;
            end
            prev_vs = vsync_in;
        end
        e    = d2;
        e.ft = fs;
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        out_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{pix: pixel, hs: hsync_out, vs: vsync_out, bl: blank_out, ft: frame_tick};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got pix=%h hs=%b vs=%b bl=%b ft=%b required pix=%h hs=%b vs=%b bl=%b ft=%b",
                         $time, g.pix, g.hs, g.vs, g.bl, g.ft, e.pix, e.hs, e.vs, e.bl, e.ft);
            end
        end
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic px(input int h, input int v);
        hcount   = 11'(h);
        vcount   = 10'(v);
        blank_in = 1'b0;
        hsync_in = 1'($urandom_range(0, 1));
        tick();
    endtask

    // Random position, mostly near the currently drawn centre
    task automatic rnd_px();
        if ($urandom_range(0, 3) == 0) begin
            hcount = 11'($urandom_range(0, 2047));
            vcount = 10'($urandom_range(0, 1023));
        end else begin
            hcount = 11'(clampi(mx + int'($urandom_range(0, 40)) - 20, 2047));
            vcount = 10'(clampi(my + int'($urandom_range(0, 40)) - 20, 1023));
        end
        blank_in = ($urandom_range(0, 7) == 0);
        hsync_in = 1'($urandom_range(0, 1));
        tick();
    endtask

    task automatic vs_start();
        vsync_in = 1'b0;
        rnd_px();
        rnd_px();
        vsync_in = 1'b1;
    endtask

    // Random frame; when chg is set the mover inputs change mid-frame
    task automatic frame(input int len, input bit chg);
        vs_start();
        for (int i = 0; i < len; i++) begin
            if (chg && $urandom_range(0, 7) == 0) begin
                x_in  = 11'($urandom_range(0, SCREEN_W - 1));
                y_in  = 10'($urandom_range(0, SCREEN_H - 1));
                show  = ($urandom_range(0, 3) != 0);
                blink = ($urandom_range(0, 3) == 0);
            end
            rnd_px();
        end
    endtask

    initial begin
        reset_n = 1'b0; hcount = '0; vcount = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
        x_in = 11'd400; y_in = 10'd300; show = 1'b1; blink = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) rnd_px();

        // Centre at 400,300: arm ends, thickness and misses
        vs_start();
        px(400, 300); px(416, 300); px(400, 284); px(401, 300);
        px(417, 300); px(402, 310); px(384, 300); px(400, 316); px(400, 317);
        blank_in = 1'b1; hcount = 11'd400; vcount = 10'd300; tick();
        x_in = 11'd500;
        px(400, 300); px(500, 300);
        repeat (10) rnd_px();
        vs_start();
        px(400, 300); px(500, 300); px(516, 301); px(499, 315);

        // Near the top-left corner: clipped arms, no wrap
        x_in = 11'd5; y_in = 10'd3;
        vs_start();
        px(0, 3); px(21, 3); px(22, 3); px(5, 0); px(5, 19); px(5, 20);
        px(1023, 3); px(5, 767); px(2047, 3); px(5, 1023);
        repeat (10) rnd_px();

        // Blink: 48 blinking frames, then steady again
        x_in = 11'd200; y_in = 10'd100; show = 1'b1; blink = 1'b1;
        for (int f = 0; f < 48; f++) begin
            vs_start();
            px(mx, my); px(mx + 3, my + 1);
            repeat (4) rnd_px();
        end
        blink = 1'b0;
        for (int f = 0; f < 2; f++) begin
            vs_start();
            px(mx, my);
            repeat (4) rnd_px();
        end

        // Random frames with mid-frame input changes
        for (int f = 0; f < 25; f++) frame(int'($urandom_range(10, 40)), 1'b1);

        // Reset in the middle of a frame
        x_in = 11'd600; y_in = 10'd400; show = 1'b1; blink = 1'b0;
        vs_start();
        px(600, 400); px(600, 400);
        x_in = 11'd700; y_in = 10'd500;
        reset_n = 1'b0; px(600, 400);
        reset_n = 1'b1;
        px(600, 400); px(700, 500); px(400, 300); px(700, 500);
        repeat (6) rnd_px();
        vs_start();
        px(700, 500); px(716, 500); px(600, 400);
        repeat (10) rnd_px();

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || n_checks < n_ticks) begin
            n_fail++;
            $display("FAIL drain got pending=%0d checked=%0d required pending=0 checked>=%0d",
                     exp_q.size(), n_checks - 1, n_ticks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crosshair_render.md
# crosshair_render

Video-side consumer of the crosshair coordinates produced by the crosshair-movement logic. Each frame it latches the current crosshair x/y at the start of vertical sync, then, for every pixel position from the VGA timing generator, decides whether that pixel lies on the crosshair and outputs its colour. Sync and blank are delayed to stay aligned with the pixel. It sits between the coordinate/mover logic and the final VGA pixel mux.

## Interface
- COLOR, 24'hFF_00_00, RGB value driven on crosshair pixels
- ARM, 16, arm half-length in pixels (arm spans centre ± ARM)
- HALF_T, 1, arm half-thickness in pixels (thickness = 2·HALF_T+1)
- BLINK_FRAMES, 15, frames per blink phase when blinking
- X_RESET, 400 / Y_RESET, 300, latched coordinates after reset
- clk  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- hcount  in  11  current pixel column
- vcount  in  10  current pixel row
- hsync_in / vsync_in  in  1  active-low syncs from timing generator
- blank_in  in  1  high outside active video
- x_in  in  11  crosshair centre column from mover
- y_in  in  10  crosshair centre row from mover
- show  in  1  crosshair enabled
- blink  in  1  blink crosshair when high
- pixel  out  24  crosshair colour or 0
- hsync_out / vsync_out / blank_out  out  1  inputs delayed 2 cycles
- frame_tick  out  1  one-cycle pulse on coordinate latch

## Operation
- vsync_in registered each cycle; falling edge (prev 1, now 0) = frame start.
- On frame start: x_l ← x_in, y_l ← y_in, show_l ← show, frame_tick=1 in the following cycle; blink logic advances.
- Coordinates are never sampled mid-frame; changes to x_in/y_in/show outside the frame-start cycle have no effect until the next frame.
- Blink: frame counter fc (0..BLINK_FRAMES-1) and phase bit ph. If blink=0 at frame start: fc←0, ph←1. Else: fc==BLINK_FRAMES-1 → fc←0, ph←~ph; otherwise fc←fc+1.
- Hit: dx=|hcount−x_l|, dy=|vcount−y_l|, computed as 12-bit signed differences (zero-extend both operands, no wrap). Horizontal arm: dy≤HALF_T and dx≤ARM. Vertical arm: dx≤HALF_T and dy≤ARM. hit = (horiz | vert) & show_l & ph.
- pixel = COLOR if hit and delayed blank=0; else 0. Arms extending past the screen edge (x_l<ARM etc.) are clipped naturally; no wrap to opposite edge.
- Reset: pixel=0, hsync_out=1, vsync_out=1, blank_out=1, frame_tick=0, x_l=X_RESET, y_l=Y_RESET, show_l=0, fc=0, ph=1, pipeline registers cleared. Reset mid-frame discards in-flight pixels; crosshair is hidden until the next frame start.

## Timing
- Stage 1: register dx, dy, hsync, vsync, blank. Stage 2: compare, colour mux, register outputs.
- Latency: hcount/vcount/syncs/blank at cycle N → pixel/sync/blank outputs at N+2.
- frame_tick asserted cycle N+1 after the vsync_in falling edge at N; latched values used from N+1 onward.
- Simultaneous reset and frame start: reset wins.

## Structure
- Shared video package: 24-bit colour type, screen size constants (1024×768), X_RESET/Y_RESET defaults shared with the mover.
- One natural sub-module: abs_diff (12-bit signed difference → 11-bit magnitude), instantiated twice.

## Test plan
- Reset, x_in=400, y_in=300, show=1, one frame → pixel=COLOR at (400,300), (416,300), (400,284), (401,300); 0 at (417,300), (402,310); output appears 2 cycles after the hcount presenting it.
- x_in changed 400→500 mid-frame → current frame still drawn at 400; next frame at 500; frame_tick pulses once per frame.
- x_in=5, y_in=3 → horizontal arm covers columns 0..21 only, vertical arm rows 0..19; no pixels at column 1023 or row 767.
- blink=1, BLINK_FRAMES=15 → crosshair visible 15 frames, hidden 15, visible 15; blink→0 → visible from next frame.
- blank_in=1 on a hit position → pixel=0; hsync_in/vsync_in/blank_in patterns reproduced exactly 2 cycles later.
- reset_n=0 mid-frame for 1 cycle → outputs at reset values next cycle, no crosshair until the following vsync falling edge, then drawn at the new x_in/y_in.
